// File: rtl/c_measure_sequencer_pkg.sv
// Shared types and default widths for the photon-counting measurement sequencer.
package c_seq_pkg;

   localparam int C_COUNTSIZE = 32;
   localparam int C_IDXSIZE   = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } seq_state_t;

   // Configuration captured at start and held for the whole run.
   // Field widths follow the package defaults.
   typedef struct packed {
      logic                   lockin;
      logic [C_COUNTSIZE-1:0] count_period;
      logic [C_COUNTSIZE-1:0] up_period;
      logic [C_COUNTSIZE-1:0] down_period;
      logic [C_COUNTSIZE-1:0] blank;
      logic [C_IDXSIZE-1:0]   num_windows;
   } shadow_cfg_t;

endpackage

// File: rtl/c_measure_sequencer_if.sv
// Control/status bundle between the PC-side controller and the measurement sequencer.
interface c_measure_sequencer_if
   import c_seq_pkg::*;
#(
   parameter int COUNTSIZE = C_COUNTSIZE,
   parameter int IDXSIZE   = C_IDXSIZE
) ();

   logic                 c_start;
   logic                 c_stop;
   logic                 c_cfg_lockin;
   logic [COUNTSIZE-1:0] c_cfg_count_period;
   logic [COUNTSIZE-1:0] c_cfg_up_period;
   logic [COUNTSIZE-1:0] c_cfg_down_period;
   logic [COUNTSIZE-1:0] c_cfg_blank;
   logic [IDXSIZE-1:0]   c_cfg_num_windows;

   logic                 c_gate;
   logic                 c_dir;
   logic                 c_lockin_inc;
   logic                 c_window_end;
   logic [IDXSIZE-1:0]   c_window_idx;
   logic                 c_busy;
   logic                 c_done;
   logic                 c_cfg_err;

   modport master (
      output c_start, c_stop, c_cfg_lockin, c_cfg_count_period, c_cfg_up_period,
             c_cfg_down_period, c_cfg_blank, c_cfg_num_windows,
      input  c_gate, c_dir, c_lockin_inc, c_window_end, c_window_idx, c_busy,
             c_done, c_cfg_err
   );

   modport slave (
      input  c_start, c_stop, c_cfg_lockin, c_cfg_count_period, c_cfg_up_period,
             c_cfg_down_period, c_cfg_blank, c_cfg_num_windows,
      output c_gate, c_dir, c_lockin_inc, c_window_end, c_window_idx, c_busy,
             c_done, c_cfg_err
   );

endinterface

// File: rtl/c_measure_sequencer_phase_timer.sv
// Phase timer: counts cycles within one phase, flags the last cycle and gates
// off the settling cycles at the phase start.
// Macro SEQ_SETTLE_BLANK_EN: when defined the blank comparator is built;
// otherwise the gate follows run_i.
module c_phase_timer
   import c_seq_pkg::*;
#(
   parameter int COUNTSIZE = C_COUNTSIZE
) (
   input  logic                 c_clk,
   input  logic                 c_rst,
   input  logic                 restart_i,  // next cycle is count 0 of a new phase
   input  logic                 run_i,      // next cycle belongs to a running phase
   input  logic [COUNTSIZE-1:0] period_i,   // length of the phase of the next cycle
   input  logic [COUNTSIZE-1:0] blank_i,
   output logic                 last_o,     // current cycle is the last of its phase
   output logic                 last_d_o,   // next cycle will be the last of its phase
   output logic                 gate_ok_o   // current cycle is gated on
);

   logic [COUNTSIZE-1:0] cnt_q, cnt_d;
   logic                 last_q;
   logic                 gate_ok_q, gate_ok_d;

   // Next phase count: restart from zero or advance.
   always_comb begin
      cnt_d = restart_i ? '0 : cnt_q + COUNTSIZE'(1);
   end

   assign last_d_o = run_i && (cnt_d == period_i - COUNTSIZE'(1));

`ifdef SEQ_SETTLE_BLANK_EN
   assign gate_ok_d = run_i && (cnt_d >= blank_i);
`else
   logic unused_blank;
   assign unused_blank = ^blank_i;
   assign gate_ok_d    = run_i;
`endif

   // Count, last-cycle and gate registers.
   always_ff @(posedge c_clk) begin
      if (c_rst) begin
         cnt_q     <= '0;
         last_q    <= 1'b0;
         gate_ok_q <= 1'b0;
      end else begin
         cnt_q     <= run_i ? cnt_d : '0;
         last_q    <= last_d_o;
         gate_ok_q <= gate_ok_d;
      end
   end

   assign last_o    = last_q;
   assign gate_ok_o = gate_ok_q;

endmodule

// File: rtl/c_measure_sequencer.sv
// Measurement sequencer: latches the configuration at start, then runs count
// windows (plain) or up/down phase pairs (lock-in), driving gate, direction,
// window-close strobe and the lock-in TTL. All outputs are registered.
// Macro SEQ_SETTLE_BLANK_EN enables the per-phase settling blank (see c_phase_timer).
module c_measure_sequencer
   import c_seq_pkg::*;
#(
   parameter int COUNTSIZE = C_COUNTSIZE,
   parameter int IDXSIZE   = C_IDXSIZE
) (
   input  logic                  c_clk,
   input  logic                  c_rst,
   c_measure_sequencer_if.slave  seq_if
);

   seq_state_t           state_q, state_d;
   shadow_cfg_t          sh_q, cfg_in, cfg_sel;
   logic [IDXSIZE-1:0]   idx_q, idx_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 busy_q, busy_d;
   logic                 dir_q, dir_d;
   logic                 inc_q, inc_d;
   logic                 wend_q, wend_d;
   logic                 restart_d;
   logic                 start_ok, cfg_bad;
   logic [COUNTSIZE-1:0] period_next;
   logic                 last_cur, last_next, gate_ok;

   // Live configuration, validity check, and the config in force next cycle
   // (the live one on the accepting start, the shadow copy otherwise).
   always_comb begin
      cfg_in              = '0;
      cfg_in.lockin       = seq_if.c_cfg_lockin;
      cfg_in.count_period = seq_if.c_cfg_count_period;
      cfg_in.up_period    = seq_if.c_cfg_up_period;
      cfg_in.down_period  = seq_if.c_cfg_down_period;
      cfg_in.blank        = seq_if.c_cfg_blank;
      cfg_in.num_windows  = seq_if.c_cfg_num_windows;
      start_ok = (state_q == IDLE) && seq_if.c_start && !seq_if.c_stop;
      cfg_bad  = cfg_in.lockin ? ((cfg_in.up_period == '0) || (cfg_in.down_period == '0))
                               : (cfg_in.count_period == '0);
      cfg_sel  = start_ok ? cfg_in : sh_q;
   end

   // Next-state logic: start, abort, window close and up-to-down hand-over.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      err_d     = err_q;
      restart_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_ok) begin
               if (cfg_bad) begin
                  err_d = 1'b1;
               end else begin
                  err_d     = 1'b0;
                  state_d   = UP;
                  idx_d     = '0;
                  restart_d = 1'b1;
               end
            end
         end
         UP, DOWN: begin
            if (seq_if.c_stop) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (wend_q) begin
               if ((sh_q.num_windows != '0) &&
                   (idx_q == sh_q.num_windows - IDXSIZE'(1))) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d     = idx_q + IDXSIZE'(1);
                  state_d   = UP;
                  restart_d = 1'b1;
               end
            end else if ((state_q == UP) && last_cur) begin
               state_d   = DOWN;
               restart_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Length of the phase the next cycle belongs to.
   always_comb begin
      period_next = cfg_sel.lockin ? cfg_sel.up_period : cfg_sel.count_period;
      if (state_d == DOWN) begin
         period_next = cfg_sel.down_period;
      end
   end

   // Next values of the registered outputs; a window closes in the last cycle
   // of DOWN (lock-in) or of UP (plain).
   always_comb begin
      busy_d = (state_d != IDLE);
      dir_d  = (state_d != DOWN);
      inc_d  = (state_d == UP) && cfg_sel.lockin;
      wend_d = last_next && ((state_d == DOWN) || ((state_d == UP) && !cfg_sel.lockin));
   end

   c_phase_timer #(.COUNTSIZE(COUNTSIZE)) u_timer (
      .c_clk     (c_clk),
      .c_rst     (c_rst),
      .restart_i (restart_d),
      .run_i     (busy_d),
      .period_i  (period_next),
      .blank_i   (cfg_sel.blank),
      .last_o    (last_cur),
      .last_d_o  (last_next),
      .gate_ok_o (gate_ok)
   );

   // State, shadow configuration and output registers.
   always_ff @(posedge c_clk) begin
      if (c_rst) begin
         state_q <= IDLE;
         sh_q    <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         dir_q   <= 1'b1;
         inc_q   <= 1'b0;
         wend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_ok) begin
            sh_q <= cfg_in;
         end
         idx_q  <= idx_d;
         done_q <= done_d;
         err_q  <= err_d;
         busy_q <= busy_d;
         dir_q  <= dir_d;
         inc_q  <= inc_d;
         wend_q <= wend_d;
      end
   end

   assign seq_if.c_gate       = gate_ok;
   assign seq_if.c_dir        = dir_q;
   assign seq_if.c_lockin_inc = inc_q;
   assign seq_if.c_window_end = wend_q;
   assign seq_if.c_window_idx = idx_q;
   assign seq_if.c_busy       = busy_q;
   assign seq_if.c_done       = done_q;
   assign seq_if.c_cfg_err    = err_q;

endmodule

// File: tb/tb_c_measure_sequencer.sv
// Testbench for c_measure_sequencer: table of run configurations with
// hand-computed per-run statistics, plus directed abort/reset sequences.
module tb_c_measure_sequencer;
   import c_seq_pkg::*;

   localparam int CS = C_COUNTSIZE;
   localparam int IS = C_IDXSIZE;

   logic c_clk = 1'b0;
   logic c_rst = 1'b1;

   c_measure_sequencer_if #(.COUNTSIZE(CS), .IDXSIZE(IS)) seq_if ();

   c_measure_sequencer #(.COUNTSIZE(CS), .IDXSIZE(IS)) dut (
      .c_clk  (c_clk),
      .c_rst  (c_rst),
      .seq_if (seq_if)
   );

   always #5 c_clk = ~c_clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic        lockin;
      int unsigned count, up, down, blank, nwin, stop_at;
      int          e_err, e_wend, e_first, e_last, e_gate_blank, e_gate_plain;
      int          e_inc, e_dirlow, e_done, e_busy;
   } vec_t;

   function automatic vec_t mk(input string name, input logic lockin,
                               input int unsigned count, up, down, blank, nwin, stop_at,
                               input int e_err, e_wend, e_first, e_last, e_gb, e_gp,
                               input int e_inc, e_dirlow, e_done, e_busy);
      vec_t v;
      v.name = name; v.lockin = lockin; v.count = count; v.up = up; v.down = down;
      v.blank = blank; v.nwin = nwin; v.stop_at = stop_at;
      v.e_err = e_err; v.e_wend = e_wend; v.e_first = e_first; v.e_last = e_last;
      v.e_gate_blank = e_gb; v.e_gate_plain = e_gp; v.e_inc = e_inc;
      v.e_dirlow = e_dirlow; v.e_done = e_done; v.e_busy = e_busy;
      return v;
   endfunction

   task automatic set_cfg(input logic lockin, input int unsigned count, up, down, blank, nwin);
      seq_if.c_cfg_lockin       = lockin;
      seq_if.c_cfg_count_period = CS'(count);
      seq_if.c_cfg_up_period    = CS'(up);
      seq_if.c_cfg_down_period  = CS'(down);
      seq_if.c_cfg_blank        = CS'(blank);
      seq_if.c_cfg_num_windows  = IS'(nwin);
   endtask

   // One start, 40 observed cycles; cycle k is sampled after the k-th edge
   // following the start edge.
   task automatic run_vec(input vec_t v);
      int n_wend = 0, first = 0, last = 0, n_gate = 0, n_inc = 0, n_dirlow = 0;
      int done_at = 0, n_done = 0, n_busy = 0, err1 = 0, exp_gate;
`ifdef SEQ_SETTLE_BLANK_EN
      exp_gate = v.e_gate_blank;
`else
      exp_gate = v.e_gate_plain;
`endif
      @(negedge c_clk);
      set_cfg(v.lockin, v.count, v.up, v.down, v.blank, v.nwin);
      seq_if.c_start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge c_clk);
         seq_if.c_start = 1'b0;
         seq_if.c_stop  = 1'b0;
         if (k == 1) err1 = int'(seq_if.c_cfg_err);
         if (seq_if.c_window_end) begin
            check({v.name, "/idx"}, seq_if.c_window_idx, n_wend);
            n_wend++;
            if (first == 0) first = k;
            last = k;
         end
         if (seq_if.c_gate) n_gate++;
         if (seq_if.c_lockin_inc) n_inc++;
         if (!seq_if.c_dir) n_dirlow++;
         if (seq_if.c_busy) n_busy++;
         if (seq_if.c_done) begin
            n_done++;
            if (done_at == 0) done_at = k;
         end
         if (k == int'(v.stop_at)) seq_if.c_stop = 1'b1;
      end
      check({v.name, "/err"},     err1,     v.e_err);
      check({v.name, "/n_wend"},  n_wend,   v.e_wend);
      check({v.name, "/first"},   first,    v.e_first);
      check({v.name, "/last"},    last,     v.e_last);
      check({v.name, "/gate"},    n_gate,   exp_gate);
      check({v.name, "/inc"},     n_inc,    v.e_inc);
      check({v.name, "/dirlow"},  n_dirlow, v.e_dirlow);
      check({v.name, "/done_at"}, done_at,  v.e_done);
      check({v.name, "/n_done"},  n_done,   (v.e_done != 0) ? 1 : 0);
      check({v.name, "/busy"},    n_busy,   v.e_busy);
      $display("vec %s: wend=%0d first=%0d last=%0d gate=%0d done_at=%0d busy=%0d",
               v.name, n_wend, first, last, n_gate, done_at, n_busy);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "/gate"}, seq_if.c_gate,        0);
      check({tag, "/dir"},  seq_if.c_dir,         1);
      check({tag, "/inc"},  seq_if.c_lockin_inc,  0);
      check({tag, "/wend"}, seq_if.c_window_end,  0);
      check({tag, "/idx"},  seq_if.c_window_idx,  0);
      check({tag, "/busy"}, seq_if.c_busy,        0);
      check({tag, "/done"}, seq_if.c_done,        0);
      check({tag, "/err"},  seq_if.c_cfg_err,     0);
   endtask

   vec_t vecs[10];

   initial begin
      int n_wend, first, done_at, n_busy, n_done, idx_w;

      // name lock cnt up dn blk nwin stop | err wend first last gateB gateP inc dirlow done busy
      vecs[0] = mk("plain5x3",   0, 5, 0, 0, 0, 3, 0,  0, 3, 5, 15, 15, 15, 0, 0, 16, 15);
      vecs[1] = mk("lock4_6b2",  1, 0, 4, 6, 2, 2, 0,  0, 2, 10, 20, 12, 20, 8, 12, 21, 20);
      vecs[2] = mk("plain1x4",   0, 1, 0, 0, 0, 4, 0,  0, 4, 1, 4, 4, 4, 0, 0, 5, 4);
      vecs[3] = mk("blank_ge_p", 0, 4, 0, 0, 4, 1, 0,  0, 1, 4, 4, 0, 4, 0, 0, 5, 4);
      vecs[4] = mk("err_cnt0",   0, 0, 7, 7, 0, 2, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[5] = mk("err_down0",  1, 5, 3, 0, 0, 2, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[6] = mk("lock1_1x3",  1, 0, 1, 1, 0, 3, 0,  0, 3, 2, 6, 6, 6, 3, 3, 7, 6);
      vecs[7] = mk("free3_stop", 0, 3, 0, 0, 0, 0, 7,  0, 2, 3, 6, 7, 7, 0, 0, 8, 7);
      vecs[8] = mk("lock2_3b1",  1, 0, 2, 3, 1, 1, 0,  0, 1, 5, 5, 3, 5, 2, 3, 6, 5);
      vecs[9] = mk("plain2_ud0", 0, 2, 0, 0, 0, 2, 0,  0, 2, 2, 4, 4, 4, 0, 0, 5, 4);

      seq_if.c_start = 1'b0;
      seq_if.c_stop  = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0);
      c_rst = 1'b1;
      repeat (3) @(negedge c_clk);
      check_reset_values("reset");
      c_rst = 1'b0;
      @(negedge c_clk);

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Start ignored while busy (with new cfg on the pins), stop on window_end.
      @(negedge c_clk);
      set_cfg(0, 4, 0, 0, 0, 0);
      seq_if.c_start = 1'b1;
      n_wend = 0; first = 0; done_at = 0; n_busy = 0; idx_w = -1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge c_clk);
         seq_if.c_start = 1'b0;
         seq_if.c_stop  = 1'b0;
         if (seq_if.c_window_end) begin
            n_wend++;
            if (first == 0) begin
               first = k;
               idx_w = int'(seq_if.c_window_idx);
            end
         end
         if (seq_if.c_busy) n_busy++;
         if (seq_if.c_done && done_at == 0) done_at = k;
         if (k == 2) begin
            seq_if.c_start = 1'b1;
            seq_if.c_cfg_count_period = CS'(2);
         end
         if (k == 4) seq_if.c_stop = 1'b1;
      end
      check("stopwe/n_wend",  n_wend,  1);
      check("stopwe/first",   first,   4);
      check("stopwe/idx",     idx_w,   0);
      check("stopwe/done_at", done_at, 5);
      check("stopwe/busy",    n_busy,  4);
      $display("seq stop_on_wend: wend=%0d first=%0d done_at=%0d busy=%0d",
               n_wend, first, done_at, n_busy);

      // Stop while idle, then simultaneous start+stop: nothing starts.
      seq_if.c_stop = 1'b1;
      @(negedge c_clk);
      seq_if.c_stop  = 1'b1;
      seq_if.c_start = 1'b1;
      set_cfg(0, 3, 0, 0, 0, 1);
      n_busy = 0; n_done = 0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge c_clk);
         seq_if.c_start = 1'b0;
         seq_if.c_stop  = 1'b0;
         if (seq_if.c_busy) n_busy++;
         if (seq_if.c_done) n_done++;
      end
      check("idle_stop/busy", n_busy, 0);
      check("idle_stop/done", n_done, 0);
      $display("seq idle_stop: busy=%0d done=%0d", n_busy, n_done);

      // Reset in the DOWN phase of the second lock-in window.
      set_cfg(1, 0, 1, 2, 0, 0);
      seq_if.c_start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge c_clk);
         seq_if.c_start = 1'b0;
         if (k == 5) begin
            check("mid_down/dir", seq_if.c_dir,        0);
            check("mid_down/idx", seq_if.c_window_idx, 1);
            c_rst = 1'b1;
         end
      end
      @(negedge c_clk);
      check_reset_values("mid_rst");
      c_rst = 1'b0;
      n_done = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge c_clk);
         if (seq_if.c_done) n_done++;
      end
      check("mid_rst/no_done", n_done, 0);
      $display("seq reset_mid_down: done_after=%0d", n_done);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
